msrv_32_pc_gen: RTL and testbench

- Parametrised, stateful successor to the combinational PC mux.
- Holds the architectural PC internally and selects the next PC from reset vector, EPC, trap vector, branch target or sequential.
- Drives the instruction-bus address with stall awareness, and buffers a redirect that arrives while the bus is not ready, so the redirect is never lost.
- Sits between the decode/branch unit, the trap/CSR unit and the AHB instruction master.

---
 rtl/msrv_32_pc_gen_if.sv | 42 ++++
 rtl/msrv_32_pc_gen.sv | 103 ++++++++++
 tb/tb_msrv_32_pc_gen.sv | 135 +++++++++++++
 3 files changed

// File: rtl/msrv_32_pc_gen_if.sv
// Control and instruction-bus signals between the PC generator and its neighbours.
// MSRV_PC_COMPRESSED_EN adds the instr_len16_in sequential-length hint.
interface msrv_32_pc_gen_if #(
    parameter int XLEN = 32
);
    logic [1:0]      pc_src_in;
    logic [XLEN-1:0] epc_in;
    logic [XLEN-1:0] trap_address_in;
    logic            branch_taken_in;
    logic [XLEN-2:0] iaddr_in;
    logic            ahb_ready_in;
`ifdef MSRV_PC_COMPRESSED_EN
    logic            instr_len16_in;
`endif

    logic [XLEN-1:0] imaddr_out;
    logic [XLEN-1:0] pc_out;
    logic [XLEN-1:0] pc_plus_4_out;
    logic [XLEN-1:0] pc_mux_out;
    logic            misaligned_instr_logic_out;
    logic            redirect_pending_out;
    logic            fetch_valid_out;

    // master: decode/trap/bus side driving the selection; slave: the PC generator
    modport master (
        output pc_src_in, epc_in, trap_address_in, branch_taken_in, iaddr_in, ahb_ready_in,
`ifdef MSRV_PC_COMPRESSED_EN
        output instr_len16_in,
`endif
        input  imaddr_out, pc_out, pc_plus_4_out, pc_mux_out,
        input  misaligned_instr_logic_out, redirect_pending_out, fetch_valid_out
    );

    modport slave (
        input  pc_src_in, epc_in, trap_address_in, branch_taken_in, iaddr_in, ahb_ready_in,
`ifdef MSRV_PC_COMPRESSED_EN
        input  instr_len16_in,
`endif
        output imaddr_out, pc_out, pc_plus_4_out, pc_mux_out,
        output misaligned_instr_logic_out, redirect_pending_out, fetch_valid_out
    );
endinterface

// File: rtl/msrv_32_pc_gen.sv
// Stateful PC generator: next-PC selection, stall-aware fetch address, redirect buffering.
// Optional macro MSRV_PC_COMPRESSED_EN enables 16-bit sequential steps and drops the alignment check.
module msrv_32_pc_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter int              INSTR_BYTES  = 4
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    msrv_32_pc_gen_if.slave   bus
);
    typedef enum logic [1:0] {BOOT, RUN, PEND} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] imaddr_q, imaddr_d;
    logic [XLEN-1:0] pending_q, pending_d;

    logic [XLEN-1:0] target;
    logic [XLEN-1:0] incr;
    logic [XLEN-1:0] next_seq;
    logic [XLEN-1:0] sel;
    logic [XLEN-1:0] pc_mux;
    logic            redirect;
    logic            misaligned;

    assign target = {bus.iaddr_in, 1'b0};

`ifdef MSRV_PC_COMPRESSED_EN
    assign incr       = bus.instr_len16_in ? XLEN'(2) : XLEN'(INSTR_BYTES);
    assign misaligned = 1'b0;
`else
    assign incr       = XLEN'(INSTR_BYTES);
    assign misaligned = (bus.pc_src_in == 2'b11) & bus.branch_taken_in & target[1];
`endif

    assign next_seq = imaddr_q + incr;
    assign redirect = (bus.pc_src_in != 2'b11) | bus.branch_taken_in;

    always_comb begin
        sel = next_seq;
        case (bus.pc_src_in)
            2'b00:   sel = RESET_VECTOR;
            2'b01:   sel = bus.epc_in;
            2'b10:   sel = bus.trap_address_in;
            default: sel = bus.branch_taken_in ? target : next_seq;
        endcase
    end

    // A buffered redirect replaces the sequential path until the bus accepts it
    assign pc_mux = (state_q == PEND && bus.pc_src_in == 2'b11 && !bus.branch_taken_in)
                    ? pending_q : sel;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (!misaligned && !bus.ahb_ready_in && redirect) state_d = PEND;
            PEND:    if (!misaligned && bus.ahb_ready_in) state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    // A misaligned target freezes everything so the trap unit can take over next cycle
    always_comb begin
        imaddr_d  = imaddr_q;
        pending_d = pending_q;
        if (state_q != BOOT && !misaligned) begin
            if (bus.ahb_ready_in) begin
                imaddr_d = pc_mux;
            end else if (redirect) begin
                pending_d = pc_mux;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            imaddr_q  <= RESET_VECTOR;
            pending_q <= '0;
        end else begin
            imaddr_q  <= imaddr_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        bus.imaddr_out                 = imaddr_q;
        bus.pc_out                     = imaddr_q;
        bus.pc_plus_4_out              = next_seq;
        bus.pc_mux_out                 = pc_mux;
        bus.misaligned_instr_logic_out = misaligned;
        bus.redirect_pending_out       = (state_q == PEND);
        bus.fetch_valid_out            = (state_q != BOOT);
    end
endmodule

// File: tb/tb_msrv_32_pc_gen.sv
// Directed vector bench for msrv_32_pc_gen: reset, branch, stall/redirect, misalign, wrap.
module tb_msrv_32_pc_gen;
    typedef struct {
        logic        rstN;
        logic [1:0]  src;
        logic        taken;
        logic [31:0] target;
        logic [31:0] epc;
        logic [31:0] trap;
        logic        ready;
        logic        chk;
        logic [31:0] expMux;
        logic        expMis;
        logic [31:0] expAddr;
        logic        expPend;
        logic        expFv;
    } vec_t;

    logic clk;
    logic rstN;
    int   testsRun;
    int   testsFailed;
    logic [31:0] prevAddr;

    msrv_32_pc_gen_if #(.XLEN(32)) busIf ();

    msrv_32_pc_gen #(
        .XLEN(32),
        .RESET_VECTOR(32'h0000_0000),
        .INSTR_BYTES(4)
    ) dut (
        .clk_in  (clk),
        .rst_n_in(rstN),
        .bus     (busIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [1:0] s, input logic t,
                                input logic [31:0] tgt, input logic [31:0] tr, input logic rdy,
                                input logic c, input logic [31:0] mux, input logic mis,
                                input logic [31:0] addr, input logic pend, input logic fv);
        vec_t v;
        v.rstN = r;  v.src = s;  v.taken = t;  v.target = tgt;
        v.epc = 32'h0000_1000;  v.trap = tr;  v.ready = rdy;  v.chk = c;
        v.expMux = mux;  v.expMis = mis;  v.expAddr = addr;  v.expPend = pend;  v.expFv = fv;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        rstN                  = v.rstN;
        busIf.pc_src_in       = v.src;
        busIf.branch_taken_in = v.taken;
        busIf.iaddr_in        = v.target[31:1];
        busIf.epc_in          = v.epc;
        busIf.trap_address_in = v.trap;
        busIf.ahb_ready_in    = v.ready;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic runVec(input vec_t v, input int idx);
        @(negedge clk);
        applyStimulus(v);
        #1;
        if (v.chk) begin
            checkOutput($sformatf("pc_mux[%0d]", idx), busIf.pc_mux_out, v.expMux);
            checkOutput($sformatf("misaligned[%0d]", idx), 32'(busIf.misaligned_instr_logic_out), 32'(v.expMis));
            checkOutput($sformatf("pc_plus_4[%0d]", idx), busIf.pc_plus_4_out, prevAddr + 32'd4);
        end
        @(posedge clk);
        #1;
        checkOutput($sformatf("imaddr[%0d]", idx), busIf.imaddr_out, v.expAddr);
        checkOutput($sformatf("pc_out[%0d]", idx), busIf.pc_out, v.expAddr);
        checkOutput($sformatf("pending[%0d]", idx), 32'(busIf.redirect_pending_out), 32'(v.expPend));
        checkOutput($sformatf("fetch_valid[%0d]", idx), 32'(busIf.fetch_valid_out), 32'(v.expFv));
        prevAddr = v.expAddr;
    endtask

    vec_t vecs[21];
    localparam logic [31:0] TRAP = 32'h8000_0000;

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        prevAddr    = 32'h0;
        rstN        = 1'b0;
`ifdef MSRV_PC_COMPRESSED_EN
        busIf.instr_len16_in = 1'b0;
`endif
        //            rst  src    tk   target         trap  rdy chk  expMux         mis  expAddr        pnd  fv
        vecs[0]  = mk(1'b0, 2'b11, 1'b0, 32'h0,        TRAP, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0);
        vecs[1]  = mk(1'b0, 2'b11, 1'b0, 32'h0,        TRAP, 1'b1, 1'b1, 32'h4,        1'b0, 32'h0,        1'b0, 1'b0);
        vecs[2]  = mk(1'b0, 2'b11, 1'b0, 32'h0,        TRAP, 1'b1, 1'b1, 32'h4,        1'b0, 32'h0,        1'b0, 1'b0);
        vecs[3]  = mk(1'b1, 2'b11, 1'b0, 32'h0,        TRAP, 1'b1, 1'b1, 32'h4,        1'b0, 32'h0,        1'b0, 1'b1);
        vecs[4]  = mk(1'b1, 2'b11, 1'b0, 32'h0,        TRAP, 1'b1, 1'b1, 32'h4,        1'b0, 32'h4,        1'b0, 1'b1);
        vecs[5]  = mk(1'b1, 2'b11, 1'b0, 32'h0,        TRAP, 1'b1, 1'b1, 32'h8,        1'b0, 32'h8,        1'b0, 1'b1);
        vecs[6]  = mk(1'b1, 2'b11, 1'b1, 32'h100,      TRAP, 1'b1, 1'b1, 32'h100,      1'b0, 32'h100,      1'b0, 1'b1);
        vecs[7]  = mk(1'b1, 2'b11, 1'b1, 32'h200,      TRAP, 1'b1, 1'b1, 32'h200,      1'b0, 32'h200,      1'b0, 1'b1);
        vecs[8]  = mk(1'b1, 2'b10, 1'b0, 32'h0,        TRAP, 1'b0, 1'b1, TRAP,         1'b0, 32'h200,      1'b1, 1'b1);
        vecs[9]  = mk(1'b1, 2'b11, 1'b1, 32'h300,      TRAP, 1'b0, 1'b1, 32'h300,      1'b0, 32'h200,      1'b1, 1'b1);
        vecs[10] = mk(1'b1, 2'b11, 1'b0, 32'h0,        TRAP, 1'b0, 1'b1, 32'h300,      1'b0, 32'h200,      1'b1, 1'b1);
        vecs[11] = mk(1'b1, 2'b11, 1'b0, 32'h0,        TRAP, 1'b1, 1'b1, 32'h300,      1'b0, 32'h300,      1'b0, 1'b1);
        vecs[12] = mk(1'b1, 2'b11, 1'b0, 32'h0,        TRAP, 1'b1, 1'b1, 32'h304,      1'b0, 32'h304,      1'b0, 1'b1);
        vecs[13] = mk(1'b1, 2'b11, 1'b0, 32'h0,        TRAP, 1'b0, 1'b1, 32'h308,      1'b0, 32'h304,      1'b0, 1'b1);
        vecs[14] = mk(1'b1, 2'b11, 1'b1, 32'h202,      TRAP, 1'b1, 1'b1, 32'h202,      1'b1, 32'h304,      1'b0, 1'b1);
        vecs[15] = mk(1'b1, 2'b10, 1'b0, 32'h0,        TRAP, 1'b1, 1'b1, TRAP,         1'b0, TRAP,         1'b0, 1'b1);
        vecs[16] = mk(1'b1, 2'b01, 1'b0, 32'h0,        TRAP, 1'b1, 1'b1, 32'h1000,     1'b0, 32'h1000,     1'b0, 1'b1);
        vecs[17] = mk(1'b1, 2'b00, 1'b0, 32'h0,        TRAP, 1'b1, 1'b1, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1);
        vecs[18] = mk(1'b1, 2'b01, 1'b1, 32'h500,      TRAP, 1'b1, 1'b1, 32'h1000,     1'b0, 32'h1000,     1'b0, 1'b1);
        vecs[19] = mk(1'b1, 2'b11, 1'b1, 32'hFFFF_FFFC, TRAP, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC, 1'b0, 1'b1);
        vecs[20] = mk(1'b1, 2'b11, 1'b0, 32'h0,        TRAP, 1'b1, 1'b1, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1);

        for (int i = 0; i < 21; i++) begin
            runVec(vecs[i], i);
        end

        // Reset while a redirect is buffered must drop it and restart from the reset vector
        runVec(mk(1'b1, 2'b11, 1'b1, 32'h400, TRAP, 1'b1, 1'b1, 32'h400, 1'b0, 32'h400, 1'b0, 1'b1), 100);
        runVec(mk(1'b1, 2'b10, 1'b0, 32'h0,   TRAP, 1'b0, 1'b1, TRAP,    1'b0, 32'h400, 1'b1, 1'b1), 101);
        runVec(mk(1'b0, 2'b10, 1'b0, 32'h0,   TRAP, 1'b0, 1'b0, TRAP,    1'b0, 32'h0,   1'b0, 1'b0), 102);
        runVec(mk(1'b1, 2'b11, 1'b0, 32'h0,   TRAP, 1'b1, 1'b1, 32'h4,   1'b0, 32'h0,   1'b0, 1'b1), 103);
        runVec(mk(1'b1, 2'b11, 1'b0, 32'h0,   TRAP, 1'b1, 1'b1, 32'h4,   1'b0, 32'h4,   1'b0, 1'b1), 104);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
